// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide unit.
// Op encodings follow funct3; FSM state encoding lives here too.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    // True when operand1 is interpreted as signed.
    function automatic logic is_signed_op(input muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_mul_op(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// One restoring-divide step on unsigned magnitudes.
// Shifts the next dividend bit into the remainder and trial-subtracts.
module muldiv_div_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted  = {rem, quo[XLEN-1]};
    assign diff     = shifted - {1'b0, divisor};
    assign rem_next = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_next = {quo[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready and kill.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] operand1_i,
    input  logic [XLEN-1:0] operand2_i,
    input  logic            kill_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] muldiv_data_o
);

    localparam int CW = $clog2(XLEN);

    state_e          state_q, state_d;
    muldiv_op_e      op_q, op_d, op_in;
    logic            neg_q, neg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [XLEN-1:0] opb_q, opb_d, data_q, data_d;

    logic            s1, s2, div_zero, div_ovf;
    logic [XLEN-1:0] mag1, mag2;
    logic [XLEN-1:0] div_rem, div_quo, quo_s, rem_s, res_fin;

    assign op_in    = muldiv_op_e'(op_i);
    assign s1       = is_signed_op(op_in) && operand1_i[XLEN-1];
    assign s2       = is_signed_op(op_in) && op_in != OP_MULHSU
                      && operand2_i[XLEN-1];
    assign mag1     = s1 ? -operand1_i : operand1_i;
    assign mag2     = s2 ? -operand2_i : operand2_i;
    assign div_zero = operand2_i == '0;
    assign div_ovf  = (op_in == OP_DIV || op_in == OP_REM)
                      && operand1_i == {1'b1, {(XLEN-1){1'b0}}}
                      && operand2_i == '1;

    muldiv_div_iter #(.XLEN(XLEN)) u_div_iter (
        .rem      (hi_q),
        .quo      (lo_q),
        .divisor  (opb_q),
        .rem_next (div_rem),
        .quo_next (div_quo)
    );

    assign quo_s = neg_q ? -div_quo : div_quo;
    assign rem_s = neg_q ? -div_rem : div_rem;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]   fast_res;

    always_comb begin
        fast_prod = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
        if (s1 ^ s2) fast_prod = -fast_prod;
        fast_res = (op_in == OP_MUL) ? fast_prod[XLEN-1:0]
                                     : fast_prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        unique case (op_q)
            OP_DIV, OP_DIVU: res_fin = quo_s;
            default:         res_fin = rem_s;
        endcase
    end
`else
    // Shift-add step: hi accumulates, lo holds the multiplier bits.
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_hi, mul_lo;
    logic [2*XLEN-1:0] prod_s;

    assign mul_sum = {1'b0, hi_q}
                   + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    assign mul_hi  = mul_sum[XLEN:1];
    assign mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
    assign prod_s  = neg_q ? -{mul_hi, mul_lo} : {mul_hi, mul_lo};

    always_comb begin
        unique case (op_q)
            OP_MUL:                       res_fin = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res_fin = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              res_fin = quo_s;
            default:                      res_fin = rem_s;
        endcase
    end
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    op_d    = op_in;
                    neg_d   = (op_in == OP_REM) ? s1 : (s1 ^ s2);
                    cnt_d   = CW'(XLEN - 1);
                    hi_d    = '0;
                    state_d = CALC;
                    if (is_mul_op(op_in)) begin
                        lo_d  = mag2;
                        opb_d = mag1;
`ifdef MULDIV_FAST_MUL_EN
                        data_d  = fast_res;
                        state_d = DONE;
`endif
                    end else begin
                        lo_d  = mag1;
                        opb_d = mag2;
                        if (div_zero) begin
                            data_d  = (op_in == OP_DIV || op_in == OP_DIVU)
                                      ? '1 : operand1_i;
                            state_d = DONE;
                        end else if (div_ovf) begin
                            data_d  = (op_in == OP_DIV) ? operand1_i : '0;
                            state_d = DONE;
                        end
                    end
                end
            end
            CALC: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else begin
`ifdef MULDIV_FAST_MUL_EN
                    hi_d = div_rem;
                    lo_d = div_quo;
`else
                    hi_d = is_mul_op(op_q) ? mul_hi : div_rem;
                    lo_d = is_mul_op(op_q) ? mul_lo : div_quo;
`endif
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        data_d  = res_fin;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (kill_i || ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q    <= OP_MUL;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            data_q  <= data_d;
        end
    end

    assign ready_o       = state_q == IDLE;
    assign valid_o       = state_q == DONE;
    assign muldiv_data_o = data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomised checks of muldiv_unit against an arithmetic model.
// Expected multiply latency follows MULDIV_FAST_MUL_EN.
module tb_muldiv_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] operand1_i = '0;
    logic [31:0] operand2_i = '0;
    logic        kill_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] muldiv_data_o;

    int n_checks = 0;
    int n_pass = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .op_i          (op_i),
        .operand1_i    (operand1_i),
        .operand2_i    (operand2_i),
        .kill_i        (kill_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .muldiv_data_o (muldiv_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model straight from the RV32M arithmetic rules.
    function automatic logic [31:0] ref_model(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // Edges after the acceptance edge until valid_o is seen.
    function automatic int exp_lat(input logic [2:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (op >= 3'd4 && b == 0) return 0;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000
            && b == 32'hFFFF_FFFF) return 0;
`ifdef MULDIV_FAST_MUL_EN
        if (op < 3'd4) return 0;
`endif
        return 32;
    endfunction

    task automatic start(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        valid_i = 1'b1;
        op_i = op;
        operand1_i = a;
        operand2_i = b;
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!valid_o && lat < 100) begin
            @(negedge clk_i);
            lat++;
        end
    endtask

    task automatic accept();
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic [2:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp, input logic chk_lat);
        int lat;
        start(op, a, b);
        wait_done(lat);
        check(tag, muldiv_data_o, exp);
        if (chk_lat) check({tag, "_lat"}, lat, exp_lat(op, a, b));
        accept();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        int seen;
        logic [31:0] a, b;

        repeat (3) @(negedge clk_i);
        check("rst_ready", ready_o, 1'b1);
        check("rst_valid", valid_o, 1'b0);
        check("rst_data", muldiv_data_o, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        run_check("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
        run_check("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000,
                  32'h4000_0000, 1'b1);
        run_check("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  32'hFFFF_FFFE, 1'b1);
        run_check("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  32'hFFFF_FFFF, 1'b1);
        run_check("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
        run_check("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        run_check("divu", 3'd5, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 1'b0);
        run_check("remu", 3'd7, 32'd100, 32'd7, 32'd2, 1'b0);
        run_check("div0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
        run_check("rem0", 3'd6, 32'd5, 32'd0, 32'd5, 1'b1);
        run_check("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
                  32'h8000_0000, 1'b1);
        run_check("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF,
                  32'd0, 1'b1);

        // Backpressure: result held while the consumer stalls.
        start(3'd5, 32'd1000, 32'd7);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_data", muldiv_data_o, 32'd142);
            check("bp_valid", valid_o, 1'b1);
            check("bp_ready", ready_o, 1'b0);
            @(negedge clk_i);
        end
        ready_i = 1'b1;
        check("hs_ready", ready_o, 1'b0);
        @(negedge clk_i);
        ready_i = 1'b0;
        check("hs_valid_low", valid_o, 1'b0);
        check("hs_ready_high", ready_o, 1'b1);

        // Kill during CALC.
        start(3'd4, 32'd12345, 32'd3);
        repeat (10) @(negedge clk_i);
        kill_i = 1'b1;
        @(negedge clk_i);
        kill_i = 1'b0;
        check("kill_ready", ready_o, 1'b1);
        check("kill_valid", valid_o, 1'b0);
        seen = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (valid_o) seen++;
        end
        check("kill_no_valid", seen, 0);

        // Kill in IDLE does not block a simultaneous request.
        kill_i = 1'b1;
        start(3'd5, 32'd50, 32'd5);
        kill_i = 1'b0;
        check("kill_idle_acc", ready_o, 1'b0);
        wait_done(lat);
        check("kill_idle_res", muldiv_data_o, 32'd10);
        accept();

        // Reset mid-CALC.
        start(3'd4, 32'd77, 32'd5);
        repeat (5) @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("mid_rst_ready", ready_o, 1'b1);
        check("mid_rst_valid", valid_o, 1'b0);
        check("mid_rst_data", muldiv_data_o, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        run_check("post_rst_divu", 3'd5, 32'd9, 32'd3, 32'd3, 1'b1);

        for (int op = 0; op < 8; op++) begin
            for (int k = 0; k < 200; k++) begin
                a = pick();
                b = pick();
                start(3'(op), a, b);
                wait_done(lat);
                check($sformatf("rnd_op%0d", op), muldiv_data_o,
                      ref_model(3'(op), a, b));
                if (k < 8)
                    check($sformatf("rnd_lat%0d", op), lat,
                          exp_lat(3'(op), a, b));
                accept();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
